// File: rtl/uart_rx.sv
// 16x-oversampled 8N1 UART receiver; rx_valid/frame_err/parity_err pulse 1 clk after stop mid-sample, no back-pressure.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
`timescale 1ns/1ps
module uart_rx (
    input  logic       clk,
    input  logic       RSTn,
    input  logic       clk_uart,
    input  logic       RXD,
    output logic [7:0] data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t     r_state, w_state;
    logic       r_rxd_meta, r_rxd_s;
    logic [3:0] r_tick_cnt, w_tick_cnt;
    logic [2:0] r_bit_cnt, w_bit_cnt;
    logic [7:0] r_shift, w_shift;
    logic [7:0] r_data, w_data;
    logic       r_rx_valid, w_rx_valid;
    logic       r_frame_err, w_frame_err;
    logic [3:0] w_tick_inc;
    logic       w_mid_bit;
`ifdef UART_RX_PARITY_EN
    logic       r_par_bad, w_par_bad;
    logic       r_parity_err, w_parity_err;
`endif

    assign w_tick_inc = r_tick_cnt + 4'd1;
    assign w_mid_bit  = clk_uart && (r_tick_cnt == 4'd15);

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_rxd_meta  <= 1'b1;
            r_rxd_s     <= 1'b1;
            r_state     <= S_IDLE;
            r_tick_cnt  <= 4'd0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rxd_meta  <= RXD;
            r_rxd_s     <= r_rxd_meta;
            r_state     <= w_state;
            r_tick_cnt  <= w_tick_cnt;
            r_bit_cnt   <= w_bit_cnt;
            r_shift     <= w_shift;
            r_data      <= w_data;
            r_rx_valid  <= w_rx_valid;
            r_frame_err <= w_frame_err;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= w_par_bad;
            r_parity_err <= w_parity_err;
`endif
        end
    end

    always_comb begin
        w_state     = r_state;
        w_tick_cnt  = r_tick_cnt;
        w_bit_cnt   = r_bit_cnt;
        w_shift     = r_shift;
        w_data      = r_data;
        w_rx_valid  = 1'b0;
        w_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad    = r_par_bad;
        w_parity_err = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                // Start detection is not tick-gated so the edge is caught at clk resolution.
                if (!r_rxd_s) begin
                    w_state    = S_START;
                    w_tick_cnt = 4'd0;
                end
            end
            S_START: begin
                if (clk_uart) begin
                    if (r_tick_cnt == 4'd7) begin
                        if (r_rxd_s) begin
                            w_state = S_IDLE;
                        end else begin
                            w_state    = S_DATA;
                            w_tick_cnt = 4'd0;
                            w_bit_cnt  = 3'd0;
                        end
                    end else begin
                        w_tick_cnt = w_tick_inc;
                    end
                end
            end
            S_DATA: begin
                if (clk_uart) w_tick_cnt = w_tick_inc;
                if (w_mid_bit) begin
                    w_shift   = {r_rxd_s, r_shift[7:1]};
                    w_bit_cnt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state = S_PARITY;
`else
                        w_state = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (clk_uart) w_tick_cnt = w_tick_inc;
                if (w_mid_bit) begin
                    w_par_bad = ^{r_shift, r_rxd_s};
                    w_state   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (clk_uart) w_tick_cnt = w_tick_inc;
                if (w_mid_bit) begin
                    if (!r_rxd_s) begin
                        w_frame_err = 1'b1;
                        w_state     = S_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                    end else if (r_par_bad) begin
                        w_parity_err = 1'b1;
                        w_state      = S_IDLE;
`endif
                    end else begin
                        w_data     = r_shift;
                        w_rx_valid = 1'b1;
                        w_state    = S_IDLE;
                    end
                end
            end
            S_WAIT_HIGH: begin
                // A held-low break must release before any new start is accepted.
                if (clk_uart && r_rxd_s) w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign data      = r_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 16 ticks/bit, one tick every 4 clk (64 clk per bit).
`timescale 1ns/1ps
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       RSTn = 1'b0;
    logic       clk_uart = 1'b0;
    logic       RXD = 1'b1;
    logic [7:0] data;
    logic       rx_valid, frame_err, parity_err, busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int n_valid = 0, n_ferr = 0, n_perr = 0, n_overlap = 0;
    logic [7:0] log_q[$];
    int tick_div = 0;

    uart_rx dut (
        .clk        (clk),
        .RSTn       (RSTn),
        .clk_uart   (clk_uart),
        .RXD        (RXD),
        .data       (data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tick_div = (tick_div + 1) % 4;
        clk_uart = (tick_div == 0);
    end

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            log_q.push_back(data);
        end
        if (frame_err) n_ferr++;
        if (parity_err) n_perr++;
        if (int'(rx_valid) + int'(frame_err) + int'(parity_err) > 1) n_overlap++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        RXD = b;
        wait_clk(64);
    endtask

    task automatic send_data(input logic [7:0] d);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        send_data(d);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_b);
    endtask

    logic [7:0] abort_byte;

    initial begin
        wait_clk(3);
        check("rst_data", data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_parity_err", parity_err, 1'b0);
        RSTn = 1'b1;
        wait_clk(20);

        // Clean frame 0x55
        send_frame(8'h55, 1'b1);
        wait_clk(128);
        check("f55_data", data, 8'h55);
        check("f55_nvalid", n_valid, 1);
        check("f55_busy", busy, 1'b0);
        check("f55_nferr", n_ferr, 0);

        // False start: low for 4 ticks
        RXD = 1'b0;
        wait_clk(8);
        check("fs_busy_mid", busy, 1'b1);
        wait_clk(8);
        RXD = 1'b1;
        wait_clk(64);
        check("fs_busy_end", busy, 1'b0);
        check("fs_nvalid", n_valid, 1);
        check("fs_nferr", n_ferr, 0);
        check("fs_data", data, 8'h55);

        // 0xA3 with stop forced low, line low for 3 bit times
        send_data(8'hA3);
`ifdef UART_RX_PARITY_EN
        send_bit(^(8'hA3));
`endif
        RXD = 1'b0;
        wait_clk(192);
        check("fe_nferr", n_ferr, 1);
        check("fe_busy_waithigh", busy, 1'b1);
        check("fe_data", data, 8'h55);
        RXD = 1'b1;
        wait_clk(128);
        check("fe_busy_end", busy, 1'b0);
        check("fe_nferr_after", n_ferr, 1);
        check("fe_nvalid", n_valid, 1);

        // Back-to-back 0x0F, 0xF0
        send_frame(8'h0F, 1'b1);
        send_frame(8'hF0, 1'b1);
        wait_clk(128);
        check("b2b_nvalid", n_valid, 3);
        check("b2b_first", (log_q.size() > 1) ? log_q[1] : 8'hxx, 8'h0F);
        check("b2b_second", (log_q.size() > 2) ? log_q[2] : 8'hxx, 8'hF0);
        check("b2b_data", data, 8'hF0);

        // Reset during data bit 4 of 0x3C, frame abandoned
        abort_byte = 8'h3C;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(abort_byte[i]);
        RXD = abort_byte[4];
        wait_clk(32);
        #2 RSTn = 1'b0;
        wait_clk(3);
        check("ar_data", data, 8'h00);
        check("ar_busy", busy, 1'b0);
        RSTn = 1'b1;
        RXD = 1'b1;
        wait_clk(64 * 12);
        check("ar_nvalid", n_valid, 3);
        check("ar_nferr", n_ferr, 1);
        send_frame(8'h81, 1'b1);
        wait_clk(128);
        check("ar_data_81", data, 8'h81);
        check("ar_nvalid_81", n_valid, 4);

`ifdef UART_RX_PARITY_EN
        send_data(8'h07);
        send_bit(1'b1);
        send_bit(1'b1);
        wait_clk(128);
        check("par_good_nvalid", n_valid, 5);
        check("par_good_data", data, 8'h07);
        send_data(8'h07);
        send_bit(1'b0);
        send_bit(1'b1);
        wait_clk(128);
        check("par_bad_nperr", n_perr, 1);
        check("par_bad_nvalid", n_valid, 5);
        check("par_bad_data", data, 8'h07);
`else
        check("nopar_nperr", n_perr, 0);
`endif
        check("no_overlap", n_overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed below, clock and reset first.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 RSTn  input  1  asynchronous active-low reset.
REQ-004 clk_uart  input  1  single-clk-cycle enable pulse at 16x the baud rate (oversampling tick).
REQ-005 RXD  input  1  serial line, idle high, asynchronous to clk.
REQ-006 data  output  8  last correctly received byte.
REQ-007 rx_valid  output  1  one-cycle pulse: data updated.
REQ-008 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 parity_err  output  1  one-cycle pulse: parity mismatch (constant 0 when parity is compiled out).
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 RXD SHALL pass through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rxd_s.
REQ-012 FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP, WAIT_HIGH.
REQ-013 Counters: 4-bit tick_cnt (0-15, wraps), 3-bit bit_cnt; tick_cnt advances only on cycles with clk_uart=1.
REQ-014 IDLE: when rxd_s=0 -> START, tick_cnt=0.
REQ-015 START: on the tick where tick_cnt=7, sample rxd_s; 1 -> IDLE (false start, no output pulse); 0 -> DATA, tick_cnt=0, bit_cnt=0.
REQ-016 DATA: on the tick where tick_cnt=15, shift rxd_s into an 8-bit shift register LSB-first (new bit enters bit 7, shift right); after bit_cnt=7 -> PARITY if compiled in, else STOP.
REQ-017 STOP: on the tick where tick_cnt=15, sample rxd_s; 1 -> data<=shift register, rx_valid=1 for exactly one clk, -> IDLE; 0 -> frame_err=1 for one clk, data unchanged, -> WAIT_HIGH.
REQ-018 WAIT_HIGH: remain until rxd_s=1, then -> IDLE; prevents a held-low line (break) from being decoded as back-to-back 0x00 frames.
REQ-019 Receive latency: rx_valid asserts on the clk after the stop-bit mid-sample tick, i.e. 9.5 bit periods after the start-bit falling edge (10.5 with parity), plus 2 clk of synchronizer delay.
REQ-020 Back-to-back frames: a start bit following the stop bit with no idle gap SHALL be received, since IDLE is re-entered at mid-stop bit.
REQ-021 No back-pressure: rx_valid SHALL NOT wait for a consumer; data holds until the next good frame overwrites it.
REQ-022 With clk_uart held at 0, the FSM and counters SHALL hold their values; only the IDLE->START transition may occur.
REQ-023 rx_valid, frame_err and parity_err SHALL never assert in the same cycle.

Reset
REQ-024 On RSTn=0, at any time including mid-frame: state=IDLE, counters=0, shift register=0, data=8'h00, rx_valid=frame_err=parity_err=0, busy=0, synchronizer flops=1.
REQ-025 After reset release, no frame SHALL be decoded until a fresh falling edge on rxd_s.

Configuration
REQ-026 Macro UART_RX_PARITY_EN, when defined: an even-parity bit follows the data bits and is sampled at tick_cnt=15 in PARITY; on mismatch, at STOP-sample time the block pulses parity_err instead of rx_valid, leaves data unchanged and returns to IDLE (WAIT_HIGH if the stop bit is also low, with frame_err taking priority).
REQ-027 Without UART_RX_PARITY_EN: no PARITY state, frame = start + 8 data + stop, and parity_err is tied to 0.

Verification
REQ-028 Frame 0x55 at 16 ticks/bit, line idle high -> data=8'h55, exactly one rx_valid pulse, busy low again after the stop mid-sample.
REQ-029 RXD low for 4 ticks then high -> no rx_valid/frame_err, busy returns to 0 at tick 7, data unchanged.
REQ-030 Frame 0xA3 with stop bit forced 0, line held low 3 bit times -> one frame_err pulse, data keeps previous value, no further pulses until the line goes high.
REQ-031 Back-to-back frames 0x0F then 0xF0 with no idle gap -> two rx_valid pulses, data=8'h0F then 8'hF0.
REQ-032 RSTn pulsed low during data bit 4 of 0x3C, then a clean frame 0x81 -> no output from the aborted frame; data=8'h81 after the second frame.
REQ-033 With UART_RX_PARITY_EN: 0x07 sent with parity bit 1 -> rx_valid; same byte with parity bit 0 -> parity_err pulse, data unchanged.
